// File: rtl/reset_sequencer.sv
// Multi-source reset controller: synchronises, debounces and qualifies reset requests and PLL lock,
// stretches sys_reset after the last trigger, and keeps a sticky cause mask and a saturating event count.
module reset_sequencer #(
    parameter int                N_SRC           = 2,
    parameter int                DEBOUNCE_CYCLES = 4,
    parameter int                STRETCH_CYCLES  = 255,
    parameter logic [N_SRC-1:0]  ACTIVE_LOW      = {N_SRC{1'b0}},
    parameter logic [N_SRC-1:0]  EDGE_MODE       = {N_SRC{1'b0}},
    parameter int                CNT_W           = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic [N_SRC-1:0]   rst_req_in,
    input  logic               cause_clear,
    output logic               sys_reset,
    output logic [N_SRC:0]     reset_cause,
    output logic [CNT_W-1:0]   reset_count,
    output logic [1:0]         state
);

    localparam logic [1:0] LOCKWAIT = 2'd0;
    localparam logic [1:0] STRETCH  = 2'd1;
    localparam logic [1:0] RUN      = 2'd2;

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX      = DW'(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0] STRETCH_LAST = SW'(STRETCH_CYCLES - 1);

    logic [N_SRC-1:0] req_sync1;
    logic [N_SRC-1:0] req_sync2;
    logic [DW-1:0]    deb_cnt [N_SRC];
    logic             pll_sync1;
    logic             pll_sync2;
    logic [SW-1:0]    stretch_cnt;

    logic [N_SRC-1:0] act;
    logic [N_SRC-1:0] qual;
    logic [N_SRC-1:0] trig;
    logic             lock;

    assign act  = req_sync2 ^ ACTIVE_LOW;
    assign lock = pll_sync2;

    // qual is itself a register (counter at max), so a qualified source whose synchronised
    // level has gone inactive is exactly the cycle before qual drops: that is the release pulse.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            qual[i] = (deb_cnt[i] == DEB_MAX);
            trig[i] = EDGE_MODE[i] ? (qual[i] & ~act[i]) : qual[i];
        end
    end

    logic [1:0]       next_state;
    logic [SW-1:0]    next_stretch;
    logic [N_SRC:0]   cause_set;
    logic             count_inc;

    always_comb begin
        next_state   = state;
        next_stretch = stretch_cnt;
        cause_set    = '0;
        count_inc    = 1'b0;
        case (state)
            LOCKWAIT: begin
                if (lock) begin
                    next_state   = STRETCH;
                    next_stretch = '0;
                end
            end
            STRETCH: begin
                if (!lock) begin
                    next_state       = LOCKWAIT;
                    cause_set[N_SRC] = 1'b1;
                end else if (|trig) begin
                    next_stretch           = '0;
                    cause_set[N_SRC-1:0]   = trig;
                end else if (stretch_cnt == STRETCH_LAST) begin
                    next_state = RUN;
                end else begin
                    next_stretch = stretch_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock) begin
                    next_state = LOCKWAIT;
                    cause_set  = {1'b1, trig};
                    count_inc  = 1'b1;
                end else if (|trig) begin
                    next_state   = STRETCH;
                    next_stretch = '0;
                    cause_set    = {1'b0, trig};
                    count_inc    = 1'b1;
                end
            end
            default: next_state = LOCKWAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_sync1   <= ACTIVE_LOW;
            req_sync2   <= ACTIVE_LOW;
            pll_sync1   <= 1'b0;
            pll_sync2   <= 1'b0;
            for (int i = 0; i < N_SRC; i++) deb_cnt[i] <= '0;
            stretch_cnt <= '0;
            state       <= LOCKWAIT;
            sys_reset   <= 1'b1;
            reset_cause <= '0;
            reset_count <= '0;
        end else begin
            req_sync1 <= rst_req_in;
            req_sync2 <= req_sync1;
            pll_sync1 <= pll_locked;
            pll_sync2 <= pll_sync1;
            for (int i = 0; i < N_SRC; i++) begin
                if (!act[i])
                    deb_cnt[i] <= '0;
                else if (deb_cnt[i] != DEB_MAX)
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
            stretch_cnt <= next_stretch;
            state       <= next_state;
            sys_reset   <= (next_state != RUN);
            // Clear first, then OR in this cycle's causes so a coincident new cause survives.
            reset_cause <= (cause_clear ? '0 : reset_cause) | cause_set;
            if (count_inc && (reset_count != {CNT_W{1'b1}}))
                reset_count <= reset_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed table of phases, hand-written corner sequences and a
// randomized run, all cross-checked every cycle against a history-window reference model.
module tb_reset_sequencer;

  localparam int N = 2;
  localparam int D = 4;
  localparam int S = 16;
  localparam int CW = 2;
  localparam logic [N-1:0] AL = 2'b10;
  localparam logic [N-1:0] EM = 2'b10;
  localparam logic [N-1:0] IDLE = 2'b10;
  localparam int H = D + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pll_locked = 1'b0;
  logic [N-1:0] rst_req_in = IDLE;
  logic cause_clear = 1'b0;
  logic sys_reset;
  logic [N:0] reset_cause;
  logic [CW-1:0] reset_count;
  logic [1:0] state;

  reset_sequencer #(
    .N_SRC(N), .DEBOUNCE_CYCLES(D), .STRETCH_CYCLES(S),
    .ACTIVE_LOW(AL), .EDGE_MODE(EM), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .rst_req_in(rst_req_in),
    .cause_clear(cause_clear), .sys_reset(sys_reset), .reset_cause(reset_cause),
    .reset_count(reset_count), .state(state)
  );

  // clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Sampled raw inputs kept as a history window (index 0 = newest edge). A source is qualified
  // when the D samples taken two or more edges back were all active; lock is the sample two back.
  logic [N-1:0] req_h [H];
  logic         pll_h [2];
  int           m_state;
  bit           m_sys;
  logic [N:0]   m_cause;
  int           m_count;
  int           edge_n = 0;
  int           release_at = 0;

  task automatic model_edge(input logic r, input logic p, input logic [N-1:0] q, input logic c);
    logic [N-1:0] trig;
    logic [N:0] bits;
    bit lock, counted, qv, a;
    if (r) begin
      for (int k = 0; k < H; k++) req_h[k] = IDLE;
      pll_h[0] = 1'b0; pll_h[1] = 1'b0;
      m_state = 0; m_sys = 1; m_cause = '0; m_count = 0;
    end else begin
      lock = pll_h[1];
      for (int i = 0; i < N; i++) begin
        qv = 1;
        for (int k = 2; k <= D + 1; k++) if ((req_h[k][i] ^ AL[i]) == 1'b0) qv = 0;
        a = req_h[1][i] ^ AL[i];
        trig[i] = EM[i] ? (qv && !a) : qv;
      end
      bits = '0;
      counted = 0;
      case (m_state)
        0: if (lock) begin m_state = 1; release_at = edge_n + S; end
        1: begin
          if (!lock) begin m_state = 0; bits[N] = 1'b1; end
          else if (trig != 0) begin release_at = edge_n + S; bits[N-1:0] = trig; end
          else if (edge_n == release_at) m_state = 2;
        end
        default: begin
          if (!lock) begin m_state = 0; bits = {1'b1, trig}; counted = 1; end
          else if (trig != 0) begin
            m_state = 1; release_at = edge_n + S; bits = {1'b0, trig}; counted = 1;
          end
        end
      endcase
      m_sys = (m_state != 2);
      m_cause = (c ? '0 : m_cause) | bits;
      if (counted && m_count < (1 << CW) - 1) m_count++;
      for (int k = H - 1; k > 0; k--) req_h[k] = req_h[k-1];
      req_h[0] = q;
      pll_h[1] = pll_h[0];
      pll_h[0] = p;
    end
    edge_n++;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
    end
  endtask

  // One clock edge: capture the inputs the DUT will sample, advance the model, compare.
  task automatic tick();
    logic r, p, c;
    logic [N-1:0] q;
    r = reset; p = pll_locked; q = rst_req_in; c = cause_clear;
    @(posedge clk);
    #1;
    model_edge(r, p, q, c);
    check("model_state", 8'(state), 8'(m_state));
    check("model_sys_reset", 8'(sys_reset), 8'(m_sys));
    check("model_cause", 8'(reset_cause), 8'(m_cause));
    check("model_count", 8'(reset_count), 8'(m_count));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic p, input logic [N-1:0] q, input logic c, input int n);
    reset = r; pll_locked = p; rst_req_in = q; cause_clear = c;
    repeat (n) tick();
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic sy,
                            input logic [N:0] ca, input logic [CW-1:0] cn);
    check({tag, "_state"}, 8'(state), 8'(st));
    check({tag, "_sys_reset"}, 8'(sys_reset), 8'(sy));
    check({tag, "_cause"}, 8'(reset_cause), 8'(ca));
    check({tag, "_count"}, 8'(reset_count), 8'(cn));
  endtask

  typedef struct {
    logic         rst;
    logic         pll;
    logic [N-1:0] req;
    logic         clr;
    int           cycles;
    logic [1:0]   st;
    logic         sys;
    logic [N:0]   cause;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int hold0, hold1, pll_down;

  initial begin
    // power-up, lock, stretch of 16
    tbl.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 3,  2'd0, 1'b1, 3'b000, 2'd0});
    tbl.push_back('{1'b0, 1'b0, 2'b10, 1'b0, 10, 2'd0, 1'b1, 3'b000, 2'd0});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 2,  2'd0, 1'b1, 3'b000, 2'd0});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 1,  2'd1, 1'b1, 3'b000, 2'd0});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 15, 2'd1, 1'b1, 3'b000, 2'd0});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 1,  2'd2, 1'b0, 3'b000, 2'd0});
    // source 0 level: glitch filtered, then held 20 cycles
    tbl.push_back('{1'b0, 1'b1, 2'b11, 1'b0, 3,  2'd2, 1'b0, 3'b000, 2'd0});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 10, 2'd2, 1'b0, 3'b000, 2'd0});
    tbl.push_back('{1'b0, 1'b1, 2'b11, 1'b0, 6,  2'd2, 1'b0, 3'b000, 2'd0});
    tbl.push_back('{1'b0, 1'b1, 2'b11, 1'b0, 1,  2'd1, 1'b1, 3'b001, 2'd1});
    tbl.push_back('{1'b0, 1'b1, 2'b11, 1'b0, 13, 2'd1, 1'b1, 3'b001, 2'd1});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 18, 2'd1, 1'b1, 3'b001, 2'd1});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 1,  2'd2, 1'b0, 3'b001, 2'd1});
    // source 1 active-low edge: fires on release
    tbl.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 10, 2'd2, 1'b0, 3'b001, 2'd1});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 2,  2'd2, 1'b0, 3'b001, 2'd1});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 1,  2'd1, 1'b1, 3'b011, 2'd2});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 15, 2'd1, 1'b1, 3'b011, 2'd2});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 1,  2'd2, 1'b0, 3'b011, 2'd2});
    // PLL loss in RUN, relock
    tbl.push_back('{1'b0, 1'b0, 2'b10, 1'b0, 2,  2'd2, 1'b0, 3'b011, 2'd2});
    tbl.push_back('{1'b0, 1'b0, 2'b10, 1'b0, 1,  2'd0, 1'b1, 3'b111, 2'd3});
    tbl.push_back('{1'b0, 1'b0, 2'b10, 1'b0, 2,  2'd0, 1'b1, 3'b111, 2'd3});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 2,  2'd0, 1'b1, 3'b111, 2'd3});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 1,  2'd1, 1'b1, 3'b111, 2'd3});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 15, 2'd1, 1'b1, 3'b111, 2'd3});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 1,  2'd2, 1'b0, 3'b111, 2'd3});
    // count saturation
    tbl.push_back('{1'b0, 1'b1, 2'b11, 1'b0, 7,  2'd1, 1'b1, 3'b111, 2'd3});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 19, 2'd2, 1'b0, 3'b111, 2'd3});
    tbl.push_back('{1'b0, 1'b1, 2'b11, 1'b0, 7,  2'd1, 1'b1, 3'b111, 2'd3});
    tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 19, 2'd2, 1'b0, 3'b111, 2'd3});

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].rst, tbl[k].pll, tbl[k].req, tbl[k].clr, tbl[k].cycles);
      expect_out($sformatf("vec%0d", k), tbl[k].st, tbl[k].sys, tbl[k].cause, tbl[k].cnt);
    end

    // cause_clear on the same edge as a source-1 release trigger
    drive(1'b0, 1'b1, 2'b00, 1'b0, 10);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 2);
    expect_out("pre_clear", 2'd2, 1'b0, 3'b111, 2'd3);
    drive(1'b0, 1'b1, 2'b10, 1'b1, 1);
    expect_out("clear_with_trig", 2'd1, 1'b1, 3'b010, 2'd3);

    // block reset at stretch count 8, then relock after reset
    drive(1'b0, 1'b1, 2'b10, 1'b0, 8);
    expect_out("mid_stretch", 2'd1, 1'b1, 3'b010, 2'd3);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1);
    expect_out("reset_mid_stretch", 2'd0, 1'b1, 3'b000, 2'd0);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 2);
    expect_out("relock_wait", 2'd0, 1'b1, 3'b000, 2'd0);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1);
    expect_out("relock_stretch", 2'd1, 1'b1, 3'b000, 2'd0);

    // randomized: held request levels, occasional PLL drops, clears and block resets
    hold0 = 0; hold1 = 0; pll_down = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold0 == 0) begin rst_req_in[0] = 1'($urandom_range(0, 1)); hold0 = $urandom_range(1, 12); end
      if (hold1 == 0) begin rst_req_in[1] = 1'($urandom_range(0, 1)); hold1 = $urandom_range(1, 12); end
      hold0--; hold1--;
      if (pll_down > 0) pll_down--;
      else if ($urandom_range(0, 199) == 0) pll_down = $urandom_range(1, 6);
      pll_locked = (pll_down == 0);
      cause_clear = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
